// File: rtl/hazard_pkg.sv
// Shared encodings and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } hz_state_t;

    localparam logic [31:0] SYSCALL_CONTINUE_V0 = 32'd34;
    localparam logic [4:0]  REG_ZERO            = 5'd0;
    localparam int          COUNTER_BITS        = 32;

endpackage

// File: rtl/cycle_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module cycle_counter
    import hazard_pkg::*;
#(
    parameter int WIDTH = COUNTER_BITS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/halt control for the 5-stage pipeline plus statistics counters.
module hazard_controller
    import hazard_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic                    id_uses_rs,
    input  logic                    id_uses_rt,
    input  logic [4:0]              ex_write,
    input  logic                    ex_regwrite,
    input  logic                    ex_memtoreg,
    input  logic                    ex_branch_taken,
    input  logic                    ex_jump,
    input  logic                    ex_syscall,
    input  logic [31:0]             ex_v0,
    output logic                    pc_en,
    output logic                    ifid_stall,
    output logic                    idex_stall,
    output logic                    exmem_stall,
    output logic                    ifid_zero,
    output logic                    idex_zero,
    output logic                    exmem_zero,
    output logic [COUNTER_BITS-1:0] total_cycles,
    output logic [COUNTER_BITS-1:0] stall_cycles,
    output logic [COUNTER_BITS-1:0] flush_count
);

    hz_state_t state, next_state;
    logic      go_q;
    logic      load_use, flush, halt_now, go_rise;
    logic      stall_evt, flush_evt;

    assign load_use = ex_memtoreg & ex_regwrite & (ex_write != REG_ZERO) &
                      ((id_uses_rs & (id_rs == ex_write)) |
                       (id_uses_rt & (id_rt == ex_write)));
    assign flush    = ex_branch_taken | ex_jump;
    assign halt_now = (state == RUN) & ex_syscall & (ex_v0 != SYSCALL_CONTINUE_V0);
    assign go_rise  = go & ~go_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            go_q  <= 1'b0;
        end else begin
            state <= next_state;
            go_q  <= go;
        end
    end

    always_comb begin
        next_state  = state;
        pc_en       = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        ifid_zero   = 1'b0;
        idex_zero   = 1'b0;
        exmem_zero  = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        if (rst) begin
            // hold PC and clock bubbles through every stage
            pc_en      = 1'b0;
            ifid_zero  = 1'b1;
            idex_zero  = 1'b1;
            exmem_zero = 1'b1;
        end else if (state == HALT) begin
            if (go_rise) begin
                next_state = RUN;
            end else begin
                pc_en      = 1'b0;
                ifid_stall = 1'b0;
                idex_stall = 1'b0;
                exmem_zero = 1'b1;
            end
        end else if (halt_now) begin
            next_state = HALT;
            pc_en      = 1'b0;
            ifid_stall = 1'b0;
            idex_stall = 1'b0;
            exmem_zero = 1'b1;
        end else if (flush) begin
            ifid_zero = 1'b1;
            idex_zero = 1'b1;
            flush_evt = 1'b1;
        end else if (load_use) begin
            // the load moves on to MEM, so the stall self-terminates next cycle
            pc_en      = 1'b0;
            ifid_stall = 1'b0;
            idex_zero  = 1'b1;
            stall_evt  = 1'b1;
        end
    end

    cycle_counter #(.WIDTH(COUNTER_BITS)) u_total (
        .clk(clk), .clr(rst), .en(state != HALT), .count(total_cycles)
    );
    cycle_counter #(.WIDTH(COUNTER_BITS)) u_stall (
        .clk(clk), .clr(rst), .en(stall_evt), .count(stall_cycles)
    );
    cycle_counter #(.WIDTH(COUNTER_BITS)) u_flush (
        .clk(clk), .clr(rst), .en(flush_evt), .count(flush_count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: stall, flush, syscall halt/release, reset, counter wrap.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst, go;
    logic [4:0]  id_rs, id_rt, ex_write;
    logic        id_uses_rs, id_uses_rt, ex_regwrite, ex_memtoreg;
    logic        ex_branch_taken, ex_jump, ex_syscall;
    logic [31:0] ex_v0;
    logic        pc_en, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_zero, idex_zero, exmem_zero;
    logic [31:0] total_cycles, stall_cycles, flush_count;
    logic        wc_clr, wc_en;
    logic [3:0]  wc_count;
    logic [6:0]  outs;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] e_tot = 0, e_stall = 0, e_flush = 0;

    // {pc_en, ifid_stall, idex_stall, exmem_stall, ifid_zero, idex_zero, exmem_zero}
    localparam logic [6:0] O_DEF   = 7'b1111_000;
    localparam logic [6:0] O_FLUSH = 7'b1111_110;
    localparam logic [6:0] O_STALL = 7'b0011_010;
    localparam logic [6:0] O_HALT  = 7'b0001_001;
    localparam logic [6:0] O_RST   = 7'b0111_111;

    always #5 clk = ~clk;

    assign outs = {pc_en, ifid_stall, idex_stall, exmem_stall, ifid_zero, idex_zero, exmem_zero};

    hazard_controller dut (
        .clk(clk), .rst(rst), .go(go),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_write(ex_write), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
        .ex_syscall(ex_syscall), .ex_v0(ex_v0),
        .pc_en(pc_en), .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
        .ifid_zero(ifid_zero), .idex_zero(idex_zero), .exmem_zero(exmem_zero),
        .total_cycles(total_cycles), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Narrow instance so the wrap boundary is reachable in a few cycles.
    cycle_counter #(.WIDTH(4)) u_wrap (.clk(clk), .clr(wc_clr), .en(wc_en), .count(wc_count));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] exp_outs);
        #1;
        chk({tag, "_outs"}, {25'd0, outs}, {25'd0, exp_outs});
        chk({tag, "_tot"}, total_cycles, e_tot);
        chk({tag, "_stall"}, stall_cycles, e_stall);
        chk({tag, "_flush"}, flush_count, e_flush);
    endtask

    // Advance one cycle; cnt says whether that edge is a non-HALT cycle.
    task automatic tick(input bit cnt);
        @(posedge clk);
        if (cnt) e_tot++;
        @(negedge clk);
    endtask

    task automatic clr_in();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_write = 0; ex_regwrite = 0; ex_memtoreg = 0;
        ex_branch_taken = 0; ex_jump = 0; ex_syscall = 0; ex_v0 = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input bit on_rt);
        ex_write = rd; ex_regwrite = 1; ex_memtoreg = 1;
        if (on_rt) begin id_rt = rd; id_uses_rt = 1; end
        else       begin id_rs = rd; id_uses_rs = 1; end
    endtask

    initial begin
        rst = 1; go = 0; wc_clr = 1; wc_en = 0;
        clr_in();
        @(negedge clk);
        chk_all("reset", O_RST);

        rst = 0;
        chk_all("first_after_reset", O_DEF);
        tick(1);

        set_load_use(5'd8, 0);
        chk_all("load_use_rs", O_STALL);
        tick(1); e_stall++;
        clr_in();
        chk_all("after_load_use", O_DEF);
        tick(1);

        set_load_use(5'd9, 1);
        chk_all("load_use_rt", O_STALL);
        tick(1); e_stall++;
        clr_in();

        set_load_use(5'd0, 0);
        chk_all("load_r0_no_stall", O_DEF);
        tick(1);
        clr_in();
        set_load_use(5'd8, 0); id_uses_rs = 0;
        chk_all("load_unused_src", O_DEF);
        tick(1);
        clr_in();

        set_load_use(5'd8, 0); ex_branch_taken = 1;
        chk_all("flush_over_load_use", O_FLUSH);
        tick(1); e_flush++;
        clr_in();
        ex_jump = 1;
        chk_all("jump_flush", O_FLUSH);
        tick(1); e_flush++;
        clr_in();

        ex_syscall = 1; ex_v0 = 32'd34;
        chk_all("syscall_34", O_DEF);
        tick(1);

        ex_v0 = 32'd10;
        chk_all("syscall_halt", O_HALT);
        tick(1);
        for (int i = 0; i < 20; i++) begin
            chk_all("halt_hold", O_HALT);
            tick(0);
        end
        go = 1;
        chk_all("go_release", O_DEF);
        tick(0);
        clr_in(); go = 0;
        chk_all("after_release", O_DEF);
        tick(1);

        ex_syscall = 1; ex_v0 = 32'd10;
        chk_all("sys1_halt", O_HALT);
        tick(1);
        go = 1;
        chk_all("sys1_release", O_DEF);
        tick(0);
        clr_in();
        for (int i = 0; i < 4; i++) begin
            chk_all("go_held_run", O_DEF);
            tick(1);
        end
        ex_syscall = 1; ex_v0 = 32'd10;
        chk_all("sys2_halt", O_HALT);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            chk_all("sys2_go_held", O_HALT);
            tick(0);
        end
        go = 0;
        chk_all("sys2_go_low", O_HALT);
        tick(0);
        go = 1;
        chk_all("sys2_release", O_DEF);
        tick(0);
        clr_in(); go = 0;
        tick(1);

        ex_syscall = 1; ex_v0 = 32'd10;
        chk_all("sys3_halt", O_HALT);
        tick(1);
        chk_all("sys3_hold", O_HALT);
        tick(0);
        rst = 1;
        e_tot = 0; e_stall = 0; e_flush = 0;
        #1;
        chk("rst_mid_halt_outs", {25'd0, outs}, {25'd0, O_RST});
        @(negedge clk);
        rst = 0;
        ex_v0 = 32'd34;
        chk_all("run_after_rst", O_DEF);
        tick(1);
        clr_in();
        chk_all("count_after_rst", O_DEF);

        wc_clr = 0; wc_en = 1;
        for (int i = 0; i < 15; i++) @(negedge clk);
        chk("wrap_max", {28'd0, wc_count}, 32'hF);
        @(negedge clk);
        chk("wrap_zero", {28'd0, wc_count}, 32'h0);
        wc_en = 0;
        @(negedge clk);
        chk("wrap_hold", {28'd0, wc_count}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all other inputs are synchronous to clk.
REQ-002 clk  in  1  pipeline clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 go  in  1  resume request after a syscall halt; level input.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 ex_write  in  5  destination register of the instruction in EX.
REQ-008 ex_regwrite, ex_memtoreg  in  1 each  EX instruction writes a register / is a load.
REQ-009 ex_branch_taken  in  1  conditional branch resolved taken in EX.
REQ-010 ex_jump  in  1  Jmp, Jr or Jal in EX.
REQ-011 ex_syscall  in  1  syscall in EX; ex_v0  in  32  $v0 value captured with it.
REQ-012 pc_en  out  1  PC load enable.
REQ-013 ifid_stall, idex_stall, exmem_stall  out  1 each  pipeline register load (1 = advance, 0 = hold).
REQ-014 ifid_zero, idex_zero, exmem_zero  out  1 each  pipeline register clear (1 = load bubble).
REQ-015 total_cycles, stall_cycles, flush_count  out  32 each  statistics counters.

Function
REQ-016 SHALL be a 2-state FSM, RUN and HALT; outputs decoded combinationally from state and inputs.
REQ-017 load_use = ex_memtoreg & ex_regwrite & (ex_write != 0) & ((id_uses_rs & id_rs == ex_write) | (id_uses_rt & id_rt == ex_write)).
REQ-018 flush = ex_branch_taken | ex_jump.
REQ-019 halt_now = (state == RUN) & ex_syscall & (ex_v0 != 34).
REQ-020 go_rise = go & ~go_q; go_q is go registered each cycle.
REQ-021 Default (no event): pc_en = 1, all *_stall = 1, all *_zero = 0.
REQ-022 flush: pc_en = 1, ifid_zero = 1, idex_zero = 1, all *_stall = 1.
REQ-023 load_use without flush: pc_en = 0, ifid_stall = 0, idex_zero = 1; stall lasts exactly 1 cycle per load.
REQ-024 Priority: halt > flush > load_use; flush and load_use together → flush only, stall_cycles not incremented.
REQ-025 halt_now in RUN: pc_en = 0, ifid_stall = 0, idex_stall = 0, exmem_zero = 1; next state HALT.
REQ-026 In HALT without go_rise: same outputs as REQ-025; the syscall stays held in EX.
REQ-027 In HALT with go_rise: default outputs for that cycle (syscall advances to MEM), halt_now ignored; next state RUN.
REQ-028 go held high does not re-release a later syscall; only a new rising edge releases.
REQ-029 ex_v0 == 34 syscall never halts and passes with default outputs.
REQ-030 total_cycles +1 every cycle not in HALT; stall_cycles +1 per REQ-023 cycle; flush_count +1 per REQ-022 cycle.
REQ-031 Counters wrap from 0xFFFFFFFF to 0; no saturation.

Reset
REQ-032 While rst = 1: pc_en = 0, all *_stall = 1, all *_zero = 1 (pipeline fills with bubbles).
REQ-033 rst SHALL set state = RUN, go_q = 0, all three counters = 0 on the next edge; rst mid-HALT returns to RUN.
REQ-034 First cycle after rst deasserts SHALL produce default outputs unless an event is present.

Structure
REQ-035 Shared package hazard_pkg holds state encoding (RUN, HALT), SYSCALL_CONTINUE_V0 = 34, REG_ZERO = 0, COUNTER_BITS = 32.
REQ-036 Sub-module cycle_counter (COUNTER_BITS-wide, enable, sync clear) SHALL be instantiated three times for the statistics counters.

Verification
REQ-037 lw $t0 in EX (ex_write = 8, memtoreg = 1), ID add reads rs = 8 → 1 cycle pc_en = 0, ifid_stall = 0, idex_zero = 1; stall_cycles = 1.
REQ-038 ex_branch_taken = 1 while load-use also matches → ifid_zero = idex_zero = 1, pc_en = 1; flush_count = 1, stall_cycles = 0.
REQ-039 Syscall with ex_v0 = 10 → HALT, outputs frozen 20 cycles, total_cycles unchanged; go pulse → 1 release cycle, then RUN.
REQ-040 Syscall with ex_v0 = 34 → no halt, default outputs, total_cycles +1.
REQ-041 go held high, two v0 = 10 syscalls 5 cycles apart → second halts until go falls and rises again.
REQ-042 Preload total_cycles to 0xFFFFFFFE via 2 cycles short of wrap, then rst mid-HALT → next cycle state RUN, counters 0; wrap test: total_cycles goes 0xFFFFFFFF → 0.
